// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter and its bit timer.
package uart_pkg;

  // Transmitter frame phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  // The stop level doubles as the idle line level.
  localparam logic STOP_LVL  = 1'b1;

  // Width of a counter that must reach cpb*sb-1 (the longest phase, STOP).
  function automatic int timer_width(input int cpb, input int sb);
    return $clog2(cpb * sb) + 1;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts clk cycles up to a terminal count and flags its expiry.
module uart_bit_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] term_i,
  output logic         bit_done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Hold at zero while loading, wrap to zero on terminal count, else count up.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (cnt_q == term_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done_o = (cnt_q == term_i);

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with a one-byte holding register so frames can run
// back-to-back. tx and busy are registered and computed from next state.
import uart_pkg::*;

module uart_tx #(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid_in,
  output logic       ready,
  output logic       tx,
  output logic       busy
);

  if ((CLKS_PER_BIT < 1) || (STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_param
    $fatal(1, "uart_tx: illegal CLKS_PER_BIT or STOP_BITS");
  end

  localparam int           CW        = timer_width(CLKS_PER_BIT, STOP_BITS);
  localparam logic [CW-1:0] TERM_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TERM_STOP = CW'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  state_e     state_q, state_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;

  logic          accept_s;
  logic          drain_s;
  logic          load_s;
  logic [CW-1:0] term_s;
  logic          bit_done_s;

  assign accept_s = data_valid_in && !hold_full_q;
  // Keep the timer parked at zero in IDLE so START always gets a full bit.
  assign load_s   = (state_q == IDLE);
  assign term_s   = (state_q == STOP) ? TERM_STOP : TERM_BIT;

  uart_bit_timer #(.W(CW)) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load_s),
    .term_i     (term_s),
    .bit_done_o (bit_done_s)
  );

  // Next-state logic: handshake into hold, frame sequencing, hold drain.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    drain_s     = 1'b0;

    if (accept_s) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          drain_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d   = START;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        if (bit_done_s) begin
          if (hold_full_q) begin
            drain_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Drain and accept are mutually exclusive: accept needs hold empty.
    if (drain_s) begin
      state_d     = START;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      bit_idx_d   = 3'd0;
    end else begin
      shift_d     = shift_d;
    end
  end

  // Line level and busy flag for the cycle after this edge.
  always_comb begin
    case (state_d)
      IDLE:    tx_d = STOP_LVL;
      START:   tx_d = START_LVL;
      DATA:    tx_d = shift_d[bit_idx_d];
      STOP:    tx_d = STOP_LVL;
      default: tx_d = STOP_LVL;
    endcase
    busy_d = (state_d != IDLE) || hold_full_d;
  end

  // State and datapath registers; reset abandons the frame and drops hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      bit_idx_q   <= 3'd0;
      tx_q        <= STOP_LVL;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign ready = !hold_full_q;
  assign tx    = tx_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 clk/bit, 1 stop; 4 clks/bit, 2 stop)
// checked every cycle against a frame-schedule reference model.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] din0 = 8'h00, din1 = 8'h00;
  logic       dv0 = 1'b0, dv1 = 1'b0;
  logic       rdy0, rdy1, tx0, tx1, busy0, busy1;

  uart_tx #(.CLKS_PER_BIT(1), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .data_in(din0), .data_valid_in(dv0),
    .ready(rdy0), .tx(tx0), .busy(busy0));

  uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .data_in(din1), .data_valid_in(dv1),
    .ready(rdy1), .tx(tx1), .busy(busy1));

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  // Model: each accepted byte becomes a frame with accept edge and start edge.
  int         fs[2][512];
  int         fa[2][512];
  logic [7:0] fd[2][512];
  int         nfr[2];
  int         line_free[2];
  bit         acc_flag[2];

  function automatic int cpb_of(int i); return (i == 0) ? 1 : 4; endfunction
  function automatic int sb_of(int i);  return (i == 0) ? 1 : 2; endfunction
  function automatic int flen(int i);   return (9 + sb_of(i)) * cpb_of(i); endfunction

  function automatic bit m_hold(int i, int t);
    int k;
    if (nfr[i] == 0) return 1'b0;
    k = nfr[i] - 1;
    return (fa[i][k] <= t) && (t < fs[i][k]);
  endfunction

  function automatic bit m_inframe(int i, int t);
    int lo;
    lo = (nfr[i] > 3) ? nfr[i] - 3 : 0;
    for (int k = nfr[i] - 1; k >= lo; k--)
      if (t >= fs[i][k] && t < fs[i][k] + flen(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_tx(int i, int t);
    int lo;
    int idx;
    int j;
    logic [7:0] b;
    lo = (nfr[i] > 3) ? nfr[i] - 3 : 0;
    for (int k = nfr[i] - 1; k >= lo; k--) begin
      if (t >= fs[i][k] && t < fs[i][k] + flen(i)) begin
        idx = (t - fs[i][k]) / cpb_of(i);
        if (idx == 0) return 1'b0;
        if (idx <= 8) begin
          b = fd[i][k];
          j = idx - 1;
          return b[j[2:0]];
        end
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  task automatic check(string name, logic act, logic exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // One clock: update the model at the edge, compare at the falling edge.
  task automatic tick();
    logic       v;
    logic [7:0] d;
    int         s;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      v = (i == 0) ? dv0 : dv1;
      d = (i == 0) ? din0 : din1;
      acc_flag[i] = 1'b0;
      if (rst) begin
        nfr[i] = 0;
        line_free[i] = 0;
      end else if (v && !m_hold(i, cyc - 1)) begin
        if (nfr[i] >= 512) begin
          $display("FAIL model_overflow inst=%0d", i);
          $fatal(1, "model capacity exceeded");
        end
        s = (cyc + 1 > line_free[i]) ? cyc + 1 : line_free[i];
        fa[i][nfr[i]] = cyc;
        fs[i][nfr[i]] = s;
        fd[i][nfr[i]] = d;
        nfr[i]++;
        line_free[i] = s + flen(i);
        acc_flag[i] = 1'b1;
      end
    end
    @(negedge clk);
    check("tx0", tx0, m_tx(0, cyc));
    check("ready0", rdy0, !m_hold(0, cyc));
    check("busy0", busy0, m_hold(0, cyc) || m_inframe(0, cyc));
    check("tx1", tx1, m_tx(1, cyc));
    check("ready1", rdy1, !m_hold(1, cyc));
    check("busy1", busy1, m_hold(1, cyc) || m_inframe(1, cyc));
    if (acc_flag[0]) dv0 = 1'b0;
    if (acc_flag[1]) dv1 = 1'b0;
  endtask

  // Offer a byte and hold it until the transfer happens (bounded wait).
  task automatic send(int i, logic [7:0] b);
    int n;
    n = 0;
    if (i == 0) begin din0 = b; dv0 = 1'b1; end
    else        begin din1 = b; dv1 = 1'b1; end
    do begin
      tick();
      n++;
    end while (!acc_flag[i] && n < 400);
    if (!acc_flag[i]) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout inst=%0d byte=%h", i, b);
      dv0 = 1'b0;
      dv1 = 1'b0;
    end
  endtask

  typedef struct {
    logic       dv;
    logic [7:0] din;
    logic       tx;
    logic       rdy;
    logic       busy;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int busy_cnt;
    int s_a;

    nfr[0] = 0; nfr[1] = 0;
    line_free[0] = 0; line_free[1] = 0;

    // 0xA5 on the 1-clk instance: accept, start, LSB-first data, stop, idle.
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0};

    // Reset for 3 cycles, then idle.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();

    // Table-driven 0xA5 frame.
    for (int j = 0; j < 13; j++) begin
      dv0  = tbl[j].dv;
      din0 = tbl[j].din;
      tick();
      check($sformatf("tbl_tx[%0d]", j), tx0, tbl[j].tx);
      check($sformatf("tbl_ready[%0d]", j), rdy0, tbl[j].rdy);
      check($sformatf("tbl_busy[%0d]", j), busy0, tbl[j].busy);
    end

    // 0x00 then 0xFF with valid held: no gap between frames.
    send(0, 8'h00);
    send(0, 8'hFF);
    repeat (25) tick();

    // 4 clks/bit, 2 stop bits: busy spans exactly the 44-cycle frame.
    send(1, 8'h3C);
    busy_cnt = 0;
    for (int j = 0; j < 60; j++) begin
      tick();
      if (busy1) busy_cnt++;
    end
    check_int("busy_len_cpb4", busy_cnt, 44);

    // Three bytes back-to-back: third stalls until hold drains.
    send(0, 8'h11);
    send(0, 8'h22);
    send(0, 8'h33);
    repeat (40) tick();

    // Reset during data bit 3 with a byte waiting in hold.
    send(0, 8'hC3);
    s_a = fs[0][nfr[0] - 1];
    send(0, 8'h96);
    while (cyc < s_a + 4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_tx", tx0, 1'b1);
    check("rst_ready", rdy0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    repeat (5) tick();
    send(0, 8'h5A);
    repeat (15) tick();

    // Random traffic on both instances.
    for (int j = 0; j < 800; j++) begin
      if (!dv0 && $urandom_range(0, 3) == 0) begin
        din0 = 8'($urandom);
        dv0  = 1'b1;
      end
      if (!dv1 && $urandom_range(0, 5) == 0) begin
        din1 = 8'($urandom);
        dv1  = 1'b1;
      end
      tick();
    end
    dv0 = 1'b0;
    dv1 = 1'b0;
    repeat (100) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
